// File: rtl/common_pkg.sv
//------------------------------------------------------------------------------
// Module : common (package)
// Brief  : Opcode constants shared by the decode pipeline.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package common;

    localparam logic [5:0] F6_J    = 6'h02;
    localparam logic [5:0] F6_JAL  = 6'h03;
    localparam logic [5:0] F6_BEQ  = 6'h04;
    localparam logic [5:0] F6_BNE  = 6'h05;
    localparam logic [5:0] F6_ANDI = 6'h0C;
    localparam logic [5:0] F6_ORI  = 6'h0D;
    localparam logic [5:0] F6_XORI = 6'h0E;

endpackage

`default_nettype wire

// File: rtl/pipes_pkg.sv
//------------------------------------------------------------------------------
// Module : pipes (package)
// Brief  : Payload types flowing between fetch and decode.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipes;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_data_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [5:0]  op;
        logic [5:0]  func;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] signimm;
    } decode_data_t;

endpackage

`default_nettype wire

// File: rtl/decode_fifo.sv
//------------------------------------------------------------------------------
// Module : decode_fifo
// Brief  : Circular buffer of DEPTH entries of type T with valid/ready ports.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module decode_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [63:0]
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_flush,
    input  logic i_valid,
    output logic o_ready,
    input  T     i_data,
    output logic o_valid,
    input  logic i_ready,
    output T     o_data
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
    localparam logic [PW-1:0] C_LAST = PW'(DEPTH - 1);

    T              r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic w_push;
    logic w_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == C_LAST) ? '0 : p + 1'b1;
    endfunction

    // Full blocks pushes even when a pop happens in the same cycle.
    assign o_ready = (r_count != C_FULL);
    assign o_valid = (r_count != '0);
    assign w_push  = i_valid && o_ready && !i_flush;
    assign w_pop   = o_valid && i_ready && !i_flush;
    assign o_data  = r_mem[r_head];

    always_ff @(posedge clk) begin
        if (!resetn || i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= next_ptr(r_tail);
            end
            if (w_pop) begin
                r_head <= next_ptr(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= i_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
//------------------------------------------------------------------------------
// Module : decode_stage
// Brief  : Buffered instruction decode with jump redirect pulse.
//          Define DECODE_JAL_EN to make JAL redirect and write rd=31.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module decode_stage
    import common::*;
    import pipes::*;
#(
    parameter int DEPTH    = 2,
    parameter int BR_SHIFT = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_pc,
    input  logic [31:0]  in_instr,
    output logic         out_valid,
    input  logic         out_ready,
    output decode_data_t out_data,
    output logic         jump_valid,
    output logic [31:0]  jump_addr
);

    fetch_data_t w_in_entry;
    fetch_data_t w_head;
    logic        w_push;
    logic        w_is_jump;
    logic [5:0]  w_op;
    logic [31:0] w_sext;
    logic        r_jump_valid;
    logic [31:0] r_jump_addr;

    assign w_in_entry = '{pc: in_pc, instr: in_instr};

    decode_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_data_t)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_flush (flush),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .i_data  (w_in_entry),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_head)
    );

    // Redirect is generated from the incoming fetch, not the head entry.
    assign w_push = in_valid && in_ready && !flush;

`ifdef DECODE_JAL_EN
    assign w_is_jump = (in_instr[31:26] == F6_J) || (in_instr[31:26] == F6_JAL);
`else
    assign w_is_jump = (in_instr[31:26] == F6_J);
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_jump_valid <= 1'b0;
            r_jump_addr  <= '0;
        end else begin
            r_jump_valid <= w_push && w_is_jump;
            if (w_push && w_is_jump) begin
                r_jump_addr <= {in_pc[31:28], in_instr[25:0], 2'b00};
            end
        end
    end

    assign jump_valid = r_jump_valid;
    assign jump_addr  = r_jump_addr;

    assign w_op   = w_head.instr[31:26];
    assign w_sext = {{16{w_head.instr[15]}}, w_head.instr[15:0]};

    always_comb begin
        out_data       = '0;
        out_data.pc    = w_head.pc;
        out_data.instr = w_head.instr;
        out_data.op    = w_op;
        out_data.func  = w_head.instr[5:0];
        out_data.rs    = w_head.instr[25:21];
        out_data.rt    = w_head.instr[20:16];
        out_data.rd    = w_head.instr[15:11];
`ifdef DECODE_JAL_EN
        if (w_op == F6_JAL) begin
            out_data.rd = 5'd31;
        end
`endif
        case (w_op)
            F6_BEQ, F6_BNE:          out_data.signimm = w_sext << BR_SHIFT;
            F6_ANDI, F6_ORI, F6_XORI: out_data.signimm = {16'h0000, w_head.instr[15:0]};
            default:                 out_data.signimm = w_sext;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
//------------------------------------------------------------------------------
// Module : tb_decode_stage
// Brief  : Directed and random checks of decode_stage against a queue model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_decode_stage;
    import pipes::*;

    localparam int DEPTH    = 2;
    localparam int BR_SHIFT = 2;
`ifdef DECODE_JAL_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         resetn;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_pc;
    logic [31:0]  in_instr;
    logic         out_valid;
    logic         out_ready;
    decode_data_t out_data;
    logic         jump_valid;
    logic [31:0]  jump_addr;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_data_t  m_q[$];
    logic         m_jv;
    logic [31:0]  m_ja;

    decode_stage #(.DEPTH(DEPTH), .BR_SHIFT(BR_SHIFT)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .jump_valid (jump_valid),
        .jump_addr  (jump_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic decode_data_t ref_decode(input logic [31:0] pc, input logic [31:0] instr);
        decode_data_t d;
        int unsigned  op  = instr >> 26;
        int           imm = int'(instr & 32'hFFFF);
        int           s   = (imm >= 32768) ? imm - 65536 : imm;
        d.pc    = pc;
        d.instr = instr;
        d.op    = 6'(op);
        d.func  = 6'(instr % 64);
        d.rs    = 5'((instr >> 21) % 32);
        d.rt    = 5'((instr >> 16) % 32);
        d.rd    = 5'((instr >> 11) % 32);
        if (op == 4 || op == 5)
            d.signimm = 32'(s * (1 << BR_SHIFT));
        else if (op >= 12 && op <= 14)
            d.signimm = 32'(imm);
        else
            d.signimm = 32'(s);
        if (JAL_EN && op == 3)
            d.rd = 5'd31;
        return d;
    endfunction

    function automatic bit ref_is_jump(input logic [31:0] instr);
        int unsigned op = instr >> 26;
        return (op == 2) || (JAL_EN && op == 3);
    endfunction

    // Compare at the falling edge, then advance the model at the rising edge.
    task automatic tick();
        bit do_push;
        bit do_pop;
        @(negedge clk);
        chk_eq("in_ready", 128'(in_ready), 128'(m_q.size() != DEPTH));
        chk_eq("out_valid", 128'(out_valid), 128'(m_q.size() != 0));
        chk_eq("jump_valid", 128'(jump_valid), 128'(m_jv));
        chk_eq("jump_addr", 128'(jump_addr), 128'(m_ja));
        if (m_q.size() != 0)
            chk_eq("out_data", 128'(out_data), 128'(ref_decode(m_q[0].pc, m_q[0].instr)));
        @(posedge clk);
        if (!resetn || flush) begin
            m_q.delete();
            m_jv = 1'b0;
            if (!resetn) m_ja = 32'h0;
        end else begin
            do_push = in_valid && (m_q.size() < DEPTH);
            do_pop  = out_ready && (m_q.size() > 0);
            m_jv    = do_push && ref_is_jump(in_instr);
            if (m_jv) m_ja = {in_pc[31:28], in_instr[25:0], 2'b00};
            if (do_pop) void'(m_q.pop_front());
            if (do_push) m_q.push_back('{pc: in_pc, instr: in_instr});
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
    endtask

    logic [5:0]  ops [10] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h00, 6'h08};
    logic [31:0] rnd;
    logic [31:0] rpc;

    initial begin
        m_jv   = 1'b0;
        m_ja   = 32'h0;
        resetn = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (2) tick();
        chk_eq("rst_in_ready", 128'(in_ready), 128'(1));
        chk_eq("rst_out_valid", 128'(out_valid), 128'(0));
        chk_eq("rst_jump_valid", 128'(jump_valid), 128'(0));
        chk_eq("rst_jump_addr", 128'(jump_addr), 128'(0));
        resetn = 1'b1;

        // LW single push
        drive(1, 32'h00400000, 32'h8C220004, 1, 0);
        tick();
        drive(0, 0, 0, 1, 0);
        chk_eq("lw_valid", 128'(out_valid), 128'(1));
        chk_eq("lw_rs", 128'(out_data.rs), 128'(1));
        chk_eq("lw_rt", 128'(out_data.rt), 128'(2));
        chk_eq("lw_imm", 128'(out_data.signimm), 128'(32'h00000004));
        tick();

        // BEQ then ORI
        drive(1, 32'h00400004, 32'h1000FFFF, 1, 0);
        tick();
        chk_eq("beq_imm", 128'(out_data.signimm), 128'(32'hFFFFFFFC));
        drive(1, 32'h00400008, 32'h34008000, 1, 0);
        tick();
        chk_eq("ori_imm", 128'(out_data.signimm), 128'(32'h00008000));
        drive(0, 0, 0, 1, 0);
        tick();

        // J redirect
        drive(1, 32'h10000000, 32'h08000040, 1, 0);
        tick();
        chk_eq("j_valid", 128'(jump_valid), 128'(1));
        chk_eq("j_addr", 128'(jump_addr), 128'(32'h10000100));
        drive(0, 0, 0, 1, 0);
        tick();
        chk_eq("j_pulse_end", 128'(jump_valid), 128'(0));
        chk_eq("j_addr_hold", 128'(jump_addr), 128'(32'h10000100));
        tick();

        // Backpressure: three pushes into a two-deep buffer
        drive(1, 32'h00000100, 32'h8C010001, 0, 0); tick();
        drive(1, 32'h00000104, 32'h8C020002, 0, 0); tick();
        chk_eq("bp_full", 128'(in_ready), 128'(0));
        drive(1, 32'h00000108, 32'h8C030003, 0, 0); tick(); tick();
        chk_eq("bp_head_a", 128'(out_data.instr), 128'(32'h8C010001));
        out_ready = 1'b1; tick();
        chk_eq("bp_head_b", 128'(out_data.instr), 128'(32'h8C020002));
        tick();
        chk_eq("bp_head_c", 128'(out_data.instr), 128'(32'h8C030003));
        drive(0, 0, 0, 1, 0); tick(); tick();

        // Flush with two buffered, a J arriving and a pop attempted
        drive(1, 32'h00000200, 32'h8C040004, 0, 0); tick();
        drive(1, 32'h00000204, 32'h8C050005, 0, 0); tick();
        drive(1, 32'h20000000, 32'h08000010, 1, 1); tick();
        chk_eq("fl_out_valid", 128'(out_valid), 128'(0));
        chk_eq("fl_jump_valid", 128'(jump_valid), 128'(0));
        chk_eq("fl_in_ready", 128'(in_ready), 128'(1));
        drive(0, 0, 0, 1, 0); tick();

        // JAL
        drive(1, 32'h00400010, 32'h0C100008, 0, 0); tick();
        chk_eq("jal_valid", 128'(jump_valid), 128'(JAL_EN));
        if (JAL_EN) begin
            chk_eq("jal_addr", 128'(jump_addr), 128'(32'h00400020));
            chk_eq("jal_rd", 128'(out_data.rd), 128'(31));
        end
        drive(0, 0, 0, 1, 0); tick(); tick();

        // Reset in mid-operation with a J arriving
        drive(1, 32'h00000300, 32'h8C060006, 0, 0); tick();
        drive(1, 32'h30000000, 32'h08000020, 0, 0); resetn = 1'b0; tick();
        resetn = 1'b1;
        chk_eq("mr_out_valid", 128'(out_valid), 128'(0));
        chk_eq("mr_jump_valid", 128'(jump_valid), 128'(0));
        chk_eq("mr_jump_addr", 128'(jump_addr), 128'(0));
        drive(0, 0, 0, 1, 0); tick();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rnd = $urandom();
            rpc = $urandom();
            in_instr  = {ops[$urandom_range(0, 9)], rnd[25:0]};
            in_pc     = rpc;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 24) == 0);
            resetn    = ($urandom_range(0, 79) != 0);
            tick();
        end
        resetn = 1'b1;
        drive(0, 0, 0, 1, 0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
